// File: rtl/seq_num_arbiter.sv
// Round-robin arbiter for the shared sequence-number generator: one create pulse per
// grant, then the converted ASCII number (or a timeout error) is returned with an ack.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 8
`endif

module seq_num_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int HOST_ADDR = `HOST_ADDR_WIDTH,
    parameter int MAX_SIZE  = 80,
    parameter int TIMEOUT   = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ*HOST_ADDR-1:0] req_host_addr_i,
    output logic [NUM_REQ-1:0]           ack_o,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [MAX_SIZE-1:0]          seq_num_o,
    output logic [3:0]                   seq_width_o,
    output logic                         err_o,
    input  logic                         update_i,
    output logic                         create_message_o,
    output logic [HOST_ADDR-1:0]         sending_to_host_addr_o,
    input  logic                         valid_seq_i,
    input  logic [MAX_SIZE-1:0]          seq_num_i,
    input  logic [3:0]                   width_seq_i
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic [HOST_ADDR-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 err_q, err_d;
    logic [MAX_SIZE-1:0]  seq_q, seq_d;
    logic [3:0]           width_q, width_d;

    logic [NUM_REQ-1:0]   req_rot_s;
    logic [IDX_W:0]       rot_sum_s;
    logic [IDX_W-1:0]     pick_s;
    logic [HOST_ADDR-1:0] pick_addr_s;
    logic                 grant_s;
    logic                 timeout_s;

    // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit then wins.
    assign req_rot_s = NUM_REQ'({req_i, req_i} >> rr_ptr_q);
    assign grant_s   = (|req_i) && !update_i;
    assign timeout_s = (cnt_q == CNT_LAST);

    // Round-robin winner selection.
    always_comb begin
        rot_sum_s = '0;
        pick_s    = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot_s[j]) begin
                rot_sum_s = {1'b0, rr_ptr_q} + (IDX_W + 1)'(j);
            end else begin
                rot_sum_s = rot_sum_s;
            end
        end
        if (rot_sum_s >= NUM_REQ_W) begin
            pick_s = IDX_W'(rot_sum_s - NUM_REQ_W);
        end else begin
            pick_s = rot_sum_s[IDX_W-1:0];
        end
    end

    // Host address of the selected requester.
    always_comb begin
        pick_addr_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_s == IDX_W'(k)) begin
                pick_addr_s = req_host_addr_i[k*HOST_ADDR +: HOST_ADDR];
            end else begin
                pick_addr_s = pick_addr_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_s) state_d = S_ISSUE;
                else         state_d = S_IDLE;
            end
            S_ISSUE: begin
                if (!update_i) state_d = S_WAIT;
                else           state_d = S_ISSUE;
            end
            S_WAIT: begin
                if (valid_seq_i || timeout_s) state_d = S_DONE;
                else                          state_d = S_WAIT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The generator favours counter updates, so the increment is only offered when update is low.
    always_comb begin
        if (state_q == S_ISSUE) begin
            create_message_o = !update_i;
        end else begin
            create_message_o = 1'b0;
        end
    end

    // Datapath next-state: grant latch, timeout count, result capture, pointer advance.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        err_d    = 1'b0;
        seq_d    = seq_q;
        width_d  = width_q;
        case (state_q)
            S_IDLE: begin
                if (grant_s) begin
                    winner_d = pick_s;
                    addr_d   = pick_addr_s;
                    gnt_d    = NUM_REQ'(1'b1) << pick_s;
                end else begin
                    gnt_d    = '0;
                end
            end
            S_ISSUE: begin
                if (!update_i) cnt_d = '0;
                else           cnt_d = cnt_q;
            end
            S_WAIT: begin
                if (valid_seq_i) begin
                    seq_d   = seq_num_i;
                    width_d = width_seq_i;
                    ack_d   = gnt_q;
                end else if (timeout_s) begin
                    seq_d   = '0;
                    width_d = 4'd0;
                    err_d   = 1'b1;
                    ack_d   = gnt_q;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1'b1);
                end
            end
            S_DONE: begin
                gnt_d = '0;
                if (winner_q == LAST_IDX) rr_ptr_d = '0;
                else                      rr_ptr_d = winner_q + IDX_W'(1'b1);
            end
            default: gnt_d = '0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            winner_q <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            seq_q    <= '0;
            width_q  <= 4'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            seq_q    <= seq_d;
            width_q  <= width_d;
        end
    end

    assign ack_o                  = ack_q;
    assign gnt_o                  = gnt_q;
    assign err_o                  = err_q;
    assign seq_num_o              = seq_q;
    assign seq_width_o            = width_q;
    assign sending_to_host_addr_o = addr_q;

endmodule

// File: tb/tb_seq_num_arbiter.sv
// Directed + randomized bench for seq_num_arbiter with a behavioural generator model
// (per-host counters rendered as 10-char ASCII) and a round-robin reference.
module tb_seq_num_arbiter;
    localparam int NR = 4;
    localparam int HA = 8;
    localparam int MS = 80;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_v;
    logic [HA-1:0] host_a [NR];
    logic [NR*HA-1:0] addr_bus;
    logic [NR-1:0] ack_o, gnt_o;
    logic [MS-1:0] seq_num_o;
    logic [3:0]    seq_width_o;
    logic          err_o, update_i, create_message_o;
    logic [HA-1:0] sending_to_host_addr_o;
    logic          gen_valid, spur_valid, valid_seq_i;
    logic [MS-1:0] gen_data, spur_data, seq_num_i;
    logic [3:0]    gen_width, width_seq_i;

    int total = 0;
    int bad   = 0;
    int gen_lat;
    int n_create;
    int m_ptr;
    int unsigned gen_cnt [256];
    int unsigned exp_cnt [256];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NR; k++) begin : g_addr
        assign addr_bus[k*HA +: HA] = host_a[k];
    end
    assign valid_seq_i = gen_valid | spur_valid;
    assign seq_num_i   = spur_valid ? spur_data : gen_data;
    assign width_seq_i = gen_width;

    seq_num_arbiter #(.NUM_REQ(NR), .HOST_ADDR(HA), .MAX_SIZE(MS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_v), .req_host_addr_i(addr_bus),
        .ack_o(ack_o), .gnt_o(gnt_o), .seq_num_o(seq_num_o), .seq_width_o(seq_width_o),
        .err_o(err_o), .update_i(update_i), .create_message_o(create_message_o),
        .sending_to_host_addr_o(sending_to_host_addr_o), .valid_seq_i(valid_seq_i),
        .seq_num_i(seq_num_i), .width_seq_i(width_seq_i)
    );

    function automatic logic [MS-1:0] ascii10(input int unsigned v);
        logic [MS-1:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < 10; i++) begin
            r = r | (MS'(8'h30 + 8'(t % 10)) << (8 * i));
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ndigits(input int unsigned v);
        int n;
        int unsigned t;
        n = 1;
        t = v;
        while (t >= 10) begin
            t = t / 10;
            n++;
        end
        return 4'(n);
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] r, input int p);
        logic [NR-1:0] t;
        for (int i = 0; i < NR; i++) begin
            t = r >> ((p + i) % NR);
            if (t[0]) return (p + i) % NR;
        end
        return 0;
    endfunction

    function automatic logic [NR-1:0] onehot(input int w);
        return NR'(1'b1) << w;
    endfunction

    task automatic chk(input string tag, input logic [MS-1:0] obs, input logic [MS-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is in an IDLE cycle with req_v already driven; that cycle is cycle 0.
    task automatic grant(input int win, input int lat, input int upd, input bit drop, input bit keep);
        logic [HA-1:0] a;
        logic [MS-1:0] exp_seq;
        int c0, cc, ackc, cyc;
        a = host_a[win[1:0]];
        gen_lat = lat;
        c0 = n_create;
        tick();
        for (int k = 0; k < upd; k++) begin
            update_i = 1'b1;
            #1;
            chk("upd_create_low", MS'(create_message_o), '0);
            chk("upd_gnt_hold", MS'(gnt_o), MS'(onehot(win)));
            chk("upd_addr_hold", MS'(sending_to_host_addr_o), MS'(a));
            tick();
        end
        update_i = 1'b0;
        #1;
        chk("issue_gnt", MS'(gnt_o), MS'(onehot(win)));
        chk("issue_addr", MS'(sending_to_host_addr_o), MS'(a));
        chk("create_pulse", MS'(create_message_o), MS'(1'b1));
        exp_cnt[a]++;
        cc = 1 + upd;
        ackc = (lat >= 0) ? cc + 2 + lat : cc + 1 + TO;
        cyc = cc;
        while (cyc < cc + TO + 8) begin
            tick();
            cyc++;
            if (cyc == cc + 2) begin
                host_a[win[1:0]] = 8'($urandom);
                if (drop) req_v = req_v & ~onehot(win);
            end
            #1;
            if (ack_o !== '0) break;
        end
        exp_seq = (lat >= 0) ? ascii10(exp_cnt[a]) : '0;
        chk("ack_cycle", MS'(cyc), MS'(ackc));
        chk("ack_vec", MS'(ack_o), MS'(onehot(win)));
        chk("ack_err", MS'(err_o), MS'(lat < 0));
        chk("ack_seq", seq_num_o, exp_seq);
        chk("ack_width", MS'(seq_width_o), MS'((lat >= 0) ? ndigits(exp_cnt[a]) : 4'd0));
        chk("ack_gnt_hold", MS'(gnt_o), MS'(onehot(win)));
        chk("ack_addr_latched", MS'(sending_to_host_addr_o), MS'(a));
        chk("one_create", MS'(n_create - c0), MS'(1));
        if (!keep) req_v = req_v & ~onehot(win);
        m_ptr = (win + 1) % NR;
        tick();
        #1;
        chk("idle_gnt", MS'(gnt_o), '0);
        chk("idle_ack", MS'(ack_o), '0);
        chk("idle_err", MS'(err_o), '0);
    endtask

    // Generator stand-in: per-host counter, answers a create pulse gen_lat cycles into WAIT.
    initial begin : gen_model
        logic [HA-1:0] ga;
        bit aborted;
        gen_valid = 1'b0;
        gen_data  = '0;
        gen_width = 4'd0;
        n_create  = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && create_message_o === 1'b1) begin
                n_create++;
                ga = sending_to_host_addr_o;
                gen_cnt[ga]++;
                if (gen_lat >= 0) begin
                    aborted = 1'b0;
                    @(posedge clk);
                    for (int i = 0; i < gen_lat && !aborted; i++) begin
                        @(posedge clk);
                        if (rst_n !== 1'b1) aborted = 1'b1;
                    end
                    if (!aborted) begin
                        #1;
                        gen_valid = 1'b1;
                        gen_data  = ascii10(gen_cnt[ga]);
                        gen_width = ndigits(gen_cnt[ga]);
                        @(posedge clk);
                        #1;
                        gen_valid = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [MS-1:0] lit52;
        logic [MS-1:0] held;
        int w, lat, upd;
        bit drp, kp;
        rst_n      = 1'b0;
        req_v      = '0;
        update_i   = 1'b0;
        spur_valid = 1'b0;
        spur_data  = '0;
        gen_lat    = -1;
        m_ptr      = 0;
        lit52      = "0000000052";
        for (int k = 0; k < NR; k++) host_a[k] = 8'(16 + k);
        repeat (3) tick();
        chk("rst_ack", MS'(ack_o), '0);
        chk("rst_gnt", MS'(gnt_o), '0);
        chk("rst_seq", seq_num_o, '0);
        chk("rst_width", MS'(seq_width_o), '0);
        chk("rst_err", MS'(err_o), '0);
        chk("rst_create", MS'(create_message_o), '0);
        chk("rst_addr", MS'(sending_to_host_addr_o), '0);
        rst_n = 1'b1;
        tick();

        // Fairness: all four held, order 0,1,2,3,0.
        req_v = '1;
        for (int i = 0; i < 5; i++) grant(i % NR, 5 + i, 0, 1'b0, i < 4);
        req_v = '0;

        // Single request: requester 2 at host 5, 33-cycle converter.
        host_a[2]  = 8'd5;
        gen_cnt[5] = 51;
        exp_cnt[5] = 51;
        req_v = 4'b0100;
        grant(2, 33, 0, 1'b0, 1'b0);
        chk("single_seq_text", seq_num_o, lit52);
        chk("single_width", MS'(seq_width_o), MS'(4'd2));

        // Update collision for 3 cycles from ISSUE.
        req_v = 4'b0010;
        grant(1, 12, 3, 1'b0, 1'b0);

        // Timeout, then the next pending requester.
        req_v = 4'b1001;
        w = rr_pick(req_v, m_ptr);
        grant(w, -1, 0, 1'b0, 1'b0);
        w = rr_pick(req_v, m_ptr);
        grant(w, 20, 0, 1'b0, 1'b0);

        // Spurious valid in IDLE, then a requester that drops req during WAIT.
        held = seq_num_o;
        spur_data  = MS'({$urandom, $urandom, $urandom});
        spur_valid = 1'b1;
        tick();
        spur_valid = 1'b0;
        #1;
        chk("spur_ack", MS'(ack_o), '0);
        chk("spur_gnt", MS'(gnt_o), '0);
        chk("spur_seq_held", seq_num_o, held);
        req_v = 4'b0100;
        grant(rr_pick(req_v, m_ptr), 15, 0, 1'b1, 1'b0);

        // Reset in the tenth WAIT cycle abandons the grant and rewinds the pointer.
        req_v = 4'b0100;
        gen_lat = 50;
        tick();
        #1;
        chk("rstw_create", MS'(create_message_o), MS'(1'b1));
        exp_cnt[host_a[2]]++;
        repeat (11) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstw_gnt", MS'(gnt_o), '0);
        chk("rstw_ack", MS'(ack_o), '0);
        chk("rstw_create0", MS'(create_message_o), '0);
        chk("rstw_addr", MS'(sending_to_host_addr_o), '0);
        chk("rstw_seq", seq_num_o, '0);
        chk("rstw_err", MS'(err_o), '0);
        req_v = 4'b1001;
        repeat (2) begin
            tick();
            #1;
            chk("rstw_no_ack", MS'(ack_o), '0);
        end
        rst_n = 1'b1;
        m_ptr = 0;
        grant(0, 10, 0, 1'b0, 1'b0);
        grant(rr_pick(req_v, m_ptr), 7, 0, 1'b0, 1'b0);

        // Randomized traffic against the round-robin reference.
        for (int n = 0; n < 24; n++) begin
            if (req_v == '0) req_v = NR'($urandom_range(1, (1 << NR) - 1));
            for (int k = 0; k < NR; k++) host_a[k] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                update_i = 1'b1;
                tick();
                #1;
                chk("idle_update_hold", MS'(gnt_o), '0);
                update_i = 1'b0;
            end
            w   = rr_pick(req_v, m_ptr);
            lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 40));
            upd = int'($urandom_range(0, 3));
            drp = 1'($urandom_range(0, 1));
            kp  = 1'($urandom_range(0, 1));
            grant(w, lat, upd, drp, kp);
            if ($urandom_range(0, 1) == 1) req_v = req_v | NR'($urandom_range(0, (1 << NR) - 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_num_arbiter.md
# seq_num_arbiter

Shares the single outgoing sequence-number path (per-host counter memory plus the multi-cycle binary-to-BCD/ASCII converter in `sequence_generator`) among several outbound message builders. It round-robin arbitrates requests, issues one `create_message` pulse per grant to the generator, waits for the converted ASCII sequence number, and returns it with a per-requester acknowledge. It sits between the message builders and `sequence_generator`, and yields to session-manager counter updates.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `HOST_ADDR`, `` `HOST_ADDR_WIDTH ``: host address width.
- `MAX_SIZE`, 80: ASCII sequence-number width (10 chars × 8 bits).
- `TIMEOUT`, 64: maximum number of WAIT cycles before an abort.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `req_i` in NUM_REQ: request, one bit per requester. Level; held until the matching ack.
- `req_host_addr_i` in NUM_REQ*HOST_ADDR: destination host address per requester. Requester k occupies slice [k*HOST_ADDR +: HOST_ADDR].
- `ack_o` out NUM_REQ: one-cycle completion pulse to the granted requester.
- `gnt_o` out NUM_REQ: one-hot current owner. Held from ISSUE through DONE.
- `seq_num_o` out MAX_SIZE: captured ASCII sequence number. Valid while `ack_o` is high.
- `seq_width_o` out 4: captured digit count. Valid with `ack_o`.
- `err_o` out 1: high with `ack_o` when the grant ended by timeout.
- `update_i` in 1: session-manager counter update (the generator's `updateSeqCounter_i`) is active this cycle.
- `create_message_o` out 1: increment-and-convert pulse to the generator.
- `sending_to_host_addr_o` out HOST_ADDR: latched address of the granted requester.
- `valid_seq_i` in 1: converter done.
- `seq_num_i` in MAX_SIZE: generator ASCII output.
- `width_seq_i` in 4: generator width output.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On `|req_i` with `update_i`=0: pick the winner round-robin, starting at `rr_ptr`. Latch the winner index and its host address. Go to ISSUE.
  - With `update_i`=1: hold in IDLE.
- **ISSUE**
  - `create_message_o` = `!update_i`. The pulse is asserted combinationally for exactly one cycle in which `update_i`=0.
  - While `update_i`=1: stay in ISSUE. The generator gives the update priority and would otherwise drop the increment.
  - On the pulse: clear the timeout counter and go to WAIT.
- **WAIT**
  - Timeout counter increments every cycle.
  - `valid_seq_i`=1: capture `seq_num_i` and `width_seq_i`, clear the error flag, go to DONE.
  - Counter reaches `TIMEOUT`-1 without valid: set the error flag and capture zeros for the data. Go to DONE.
  - If both conditions occur in the same cycle, valid wins.
- **DONE**
  - `ack_o[winner]`=1 for one cycle; `err_o` = error flag.
  - `rr_ptr` ← (winner+1) mod NUM_REQ.
  - Go to IDLE.
- `valid_seq_i` outside WAIT is ignored.
- A requester dropping `req_i` after grant does not abort the grant: the counter has already incremented, so the ack is still issued.
- A requester may re-request in the cycle after its ack. It competes normally under round-robin.
- `sending_to_host_addr_o` holds the last latched address in IDLE. It is stable from ISSUE through DONE.

## Timing
- Reset values: all outputs 0, `gnt_o`=0, `rr_ptr`=0, state IDLE.
- Async assert of `rst_n` takes effect immediately, mid-operation included. Any in-flight grant is abandoned with no ack. Deassertion is synchronous to `clk` at the next edge.
- Request sampled in IDLE at cycle 0:
  - ISSUE at cycle 1, with `create_message_o` at cycle 1 if `update_i`=0.
  - WAIT from cycle 2.
  - If `valid_seq_i` arrives at cycle 2+L, `ack_o` is high at cycle 3+L.
- Minimum turnaround is 4 cycles per grant plus converter latency L (about 33 cycles for the 32-bit converter).
- A timeout ack occurs at cycle 2+TIMEOUT.
- Exactly one `create_message_o` pulse per grant, never two, even with `update_i` toggling.

## Test plan
- **Single request.** Req 2 (host 5) rises; generator model returns valid after 33 cycles with "0000000052" and width 2. Required: `create_message_o` at cycle 1 with addr 5; `ack_o`=4'b0100 at cycle 36; `seq_num_o` matches; `err_o`=0.
- **Round-robin fairness.** All four requests held continuously. Required: grant order 0,1,2,3,0. Each ack carries its own host address. Exactly one create pulse per grant.
- **Update collision.** `update_i` high for 3 cycles starting at ISSUE. Required: `create_message_o` stays low for those 3 cycles, then a single pulse. Grant and address are unchanged throughout.
- **Timeout.** Model never asserts valid, TIMEOUT=64. Required: ack at cycle 66 with `err_o`=1 and `seq_num_o`=0. The next requester is then granted normally.
- **Reset mid-WAIT.** `rst_n` pulled low at WAIT cycle 10. Required: outputs go to 0 immediately with no ack. After release, a pending req 0 is granted first (`rr_ptr`=0).
- **Spurious valid and early request drop.** `valid_seq_i` pulsed in IDLE is ignored. The requester drops `req_i` during WAIT. Required: ack is still delivered on the valid.
